// File: rtl/tetris_pkg.sv
// Shared playfield geometry, shape codes and the piece-controller state encoding.
package tetris_pkg;

  localparam logic [9:0] BLOCK_SIZE = 10'd20;
  localparam logic [9:0] HORI_SIZE  = 10'd640;
  localparam logic [9:0] VERT_SIZE  = 10'd480;
  localparam logic [9:0] SPAWN_X    = 10'd280;

  localparam logic [2:0] SHAPE_SQUARE = 3'd0;
  localparam logic [2:0] SHAPE_HBAR   = 3'd1;
  localparam logic [2:0] SHAPE_VBAR   = 3'd2;

  typedef enum logic [2:0] {
    RESET_ACK,
    SPAWN,
    FALL,
    LOCK,
    GAME_OVER
  } state_t;

  // Width of a shape in grid cells, used for the right-wall bound.
  function automatic logic [2:0] shape_width(input logic [2:0] shape);
    case (shape)
      SHAPE_SQUARE: return 3'd2;
      SHAPE_HBAR:   return 3'd4;
      SHAPE_VBAR:   return 3'd1;
      default:      return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/piece_ctrl_if.sv
// Buttons and color_mux feedback in, piece position and sequencing pulses out.
interface piece_ctrl_if;

  logic       btn_left;
  logic       btn_right;
  logic       btn_drop;
  logic       stop;
  logic       hit;
  logic [2:0] shape;
  logic [9:0] ref_x;
  logic [9:0] ref_y;
  logic       change_shape;
  logic       reset_ack;
  logic       game_over;

  modport master (
    input  btn_left, btn_right, btn_drop, stop, hit, shape,
    output ref_x, ref_y, change_shape, reset_ack, game_over
  );

  modport slave (
    output btn_left, btn_right, btn_drop, stop, hit, shape,
    input  ref_x, ref_y, change_shape, reset_ack, game_over
  );

endinterface

// File: rtl/btn_edge.sv
// One-register rising-edge detector; the history register updates every cycle.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b0;
    else       r_prev <= i_btn;
  end

  assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/piece_ctrl.sv
// Falling-piece motion controller: spawn, gravity, lateral moves, lock and game-over.
// Position registered; stop/hit are used combinationally in the cycle they arrive.
module piece_ctrl
  import tetris_pkg::*;
#(
  parameter int FALL_DIV    = 1_250_000,
  parameter int FAST_DIV    = 125_000,
  parameter int LOCK_CYCLES = 4
) (
  input logic          iVGA_CLK,
  input logic          reset,
  piece_ctrl_if.master bus
);

  localparam int              LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [20:0]     FALL_LIM  = 21'(FALL_DIV - 1);
  localparam logic [20:0]     FAST_LIM  = 21'(FAST_DIV - 1);

  state_t            r_state;
  logic [9:0]        r_ref_x;
  logic [9:0]        r_ref_y;
  logic [20:0]       r_cnt;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_first;

  state_t            w_state_nxt;
  logic [9:0]        w_ref_x_nxt;
  logic [9:0]        w_ref_y_nxt;
  logic [20:0]       w_cnt_nxt;
  logic [LOCK_W-1:0] w_lock_cnt_nxt;
  logic              w_first_nxt;

  logic        w_left_rise;
  logic        w_right_rise;
  logic        w_unused_drop_rise;
  logic [20:0] w_lim;
  logic        w_tick;
  logic [11:0] w_right_end;
  logic        w_left_ok;
  logic        w_right_ok;

  btn_edge u_edge_left (
    .i_clk  (iVGA_CLK),
    .i_rst  (reset),
    .i_btn  (bus.btn_left),
    .o_rise (w_left_rise)
  );

  btn_edge u_edge_right (
    .i_clk  (iVGA_CLK),
    .i_rst  (reset),
    .i_btn  (bus.btn_right),
    .o_rise (w_right_rise)
  );

  // Drop edge is reserved for a future hard-drop; gravity uses the held level.
  btn_edge u_edge_drop (
    .i_clk  (iVGA_CLK),
    .i_rst  (reset),
    .i_btn  (bus.btn_drop),
    .o_rise (w_unused_drop_rise)
  );

  assign w_lim  = bus.btn_drop ? FAST_LIM : FALL_LIM;
  assign w_tick = (r_cnt >= w_lim);

  // Right bound in 12 bits so the sum cannot wrap before the compare.
  assign w_right_end = 12'(r_ref_x) + 12'(shape_width(bus.shape) + 3'd1) * 12'(BLOCK_SIZE);

  assign w_left_ok  = w_left_rise & ~w_right_rise & ~bus.hit & (r_ref_x >= BLOCK_SIZE);
  assign w_right_ok = w_right_rise & ~w_left_rise & ~bus.hit & (w_right_end <= 12'(HORI_SIZE));

  always_comb begin
    w_state_nxt    = r_state;
    w_ref_x_nxt    = r_ref_x;
    w_ref_y_nxt    = r_ref_y;
    w_cnt_nxt      = r_cnt;
    w_lock_cnt_nxt = r_lock_cnt;
    w_first_nxt    = r_first;

    case (r_state)
      RESET_ACK: w_state_nxt = SPAWN;

      SPAWN: begin
        w_ref_x_nxt = SPAWN_X;
        w_ref_y_nxt = 10'd0;
        w_cnt_nxt   = 21'd0;
        w_first_nxt = 1'b1;
        w_state_nxt = FALL;
      end

      FALL: begin
        w_first_nxt = 1'b0;
        if (r_first && bus.stop) begin
          // Spawned on top of the stack: no room to enter the playfield.
          w_state_nxt = GAME_OVER;
        end else if (w_tick && bus.stop) begin
          w_state_nxt    = LOCK;
          w_lock_cnt_nxt = '0;
          w_cnt_nxt      = 21'd0;
        end else begin
          w_cnt_nxt = w_tick ? 21'd0 : r_cnt + 21'd1;
          if (w_tick) w_ref_y_nxt = r_ref_y + BLOCK_SIZE;
          if (w_left_ok)       w_ref_x_nxt = r_ref_x - BLOCK_SIZE;
          else if (w_right_ok) w_ref_x_nxt = r_ref_x + BLOCK_SIZE;
        end
      end

      LOCK: begin
        if (r_lock_cnt == LOCK_LAST) w_state_nxt = SPAWN;
        else                         w_lock_cnt_nxt = r_lock_cnt + 1'b1;
      end

      GAME_OVER: w_state_nxt = GAME_OVER;

      default: w_state_nxt = RESET_ACK;
    endcase
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      r_state    <= RESET_ACK;
      r_ref_x    <= SPAWN_X;
      r_ref_y    <= 10'd0;
      r_cnt      <= 21'd0;
      r_lock_cnt <= '0;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ref_x    <= w_ref_x_nxt;
      r_ref_y    <= w_ref_y_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_first    <= w_first_nxt;
    end
  end

  assign bus.ref_x        = r_ref_x;
  assign bus.ref_y        = r_ref_y;
  assign bus.change_shape = (r_state == SPAWN);
  assign bus.reset_ack    = (r_state == RESET_ACK) & ~reset;
  assign bus.game_over    = (r_state == GAME_OVER);

endmodule

// File: doc/piece_ctrl.md
# piece_ctrl

Active-piece motion controller, directly upstream of `color_mux`. Generates the falling piece's reference point (`ref_x`, `ref_y`) from a gravity timer and left/right/drop buttons, and obeys `stop`/`hit` fed back from `color_mux`. It sequences spawn, fall, lock and game-over, pulsing `change_shape` at each spawn and `reset_ack` after reset.

## Interface
- `BLOCK_SIZE`, 20: grid cell size in pixels.
- `HORI_SIZE`, 640: playfield width in pixels.
- `SPAWN_X`, 280: spawn `ref_x` (spawn `ref_y` = 0).
- `FALL_DIV`, 1_250_000: clocks per gravity step, normal.
- `FAST_DIV`, 125_000: clocks per gravity step while `btn_drop` is held.
- `LOCK_CYCLES`, 4: clocks spent in LOCK so `color_mux` can commit the piece.
- `iVGA_CLK`  in  1  the only clock.
- `reset`  in  1  synchronous, active-high.
- `btn_left`, `btn_right`, `btn_drop`  in  1 each  buttons, already synchronous to `iVGA_CLK`, active-high.
- `stop`  in  1  from `color_mux`; piece can't fall further.
- `hit`  in  1  from `color_mux`; lateral move blocked.
- `shape`  in  3  current shape code from `color_mux`.
- `ref_x`, `ref_y`  out  10 each  piece top-left, pixels, registered.
- `change_shape`  out  1  one-cycle pulse on each spawn.
- `reset_ack`  out  1  one-cycle pulse, first cycle after `reset` deasserts.
- `game_over`  out  1  sticky until `reset`.

## Operation
- States: RESET_ACK, SPAWN, FALL, LOCK, GAME_OVER.
- Reset values: state RESET_ACK, `ref_x`=`SPAWN_X`, `ref_y`=0, `change_shape`=0, `reset_ack`=0, `game_over`=0, gravity counter 0, button history registers 0.
- RESET_ACK: assert `reset_ack` for one cycle, go to SPAWN.
- SPAWN (one cycle): `ref_x`←`SPAWN_X`, `ref_y`←0, `change_shape`=1, counter←0, go to FALL.
- FALL
  - Gravity counter increments each cycle. Tick when counter ≥ div−1, with div = `FAST_DIV` if `btn_drop` else `FALL_DIV`. On tick the counter clears.
  - Tick with `stop`=1: go to LOCK; `ref_y` and `ref_x` hold.
  - Tick with `stop`=0: `ref_y` += `BLOCK_SIZE`.
  - First FALL cycle after SPAWN with `stop`=1: go to GAME_OVER.
- Lateral moves in FALL only, on rising edge (current=1, previous sample=0):
  - Left: applied if `hit`=0 and `ref_x` ≥ `BLOCK_SIZE`; `ref_x` −= `BLOCK_SIZE`.
  - Right: applied if `hit`=0 and `ref_x` + (w+1)·`BLOCK_SIZE` ≤ `HORI_SIZE`; `ref_x` += `BLOCK_SIZE`.
  - w = shape width in cells: 0→2, 1→4, 2→1, others→1.
  - Both edges in the same cycle: neither applied.
  - Move plus gravity tick in the same cycle: both applied (x and y independent), except a tick with `stop`=1, which suppresses the move.
- LOCK: count `LOCK_CYCLES` clocks with position frozen, then go to SPAWN. Buttons are ignored, but history keeps updating, so no stale edge fires later.
- GAME_OVER: `game_over`=1; position frozen; leave only via `reset`.
- `reset` in any state, mid-fall or mid-lock: all registers return to reset values at that edge.
- Arithmetic: 10-bit unsigned. The bound checks above guarantee no wrap. Gravity counter is 21 bits.

## Timing
- Button edge sampled at edge k: new `ref_x` visible after edge k (1-cycle latency).
- Gravity tick at edge k: `ref_y` updated after edge k.
- `stop` and `hit` are sampled in the cycle they are used; no internal re-registering.
- Spawn-to-spawn minimum: 1 (SPAWN) + div (first tick) + `LOCK_CYCLES`.
- `change_shape` is high exactly in the cycle the state register is SPAWN. `ref_x`/`ref_y` show spawn values from the next cycle.
- `reset_ack` is high in the single RESET_ACK cycle.

## Structure
- Shared package `tetris_pkg`:
  - constants `BLOCK_SIZE`, `HORI_SIZE`, `VERT_SIZE`, `SPAWN_X`
  - shape codes `SHAPE_SQUARE`=0, `SHAPE_HBAR`=1, `SHAPE_VBAR`=2
  - shape-width function
  - state encoding typedef
- Sub-module `btn_edge`: one-register rising-edge detector, instantiated three times (left, right, drop; drop edge unused but kept for later hard-drop).

## Test plan
Bench parameters: `FALL_DIV`=4, `FAST_DIV`=1, `LOCK_CYCLES`=2.
- Reset release, `stop`=`hit`=0 → `reset_ack` 1 cycle, next cycle `change_shape` 1 cycle, then `ref_y` = 0, 20, 40 every 4 clocks at `ref_x`=280.
- `btn_left` held 10 cycles → `ref_x` 280→260 once. At `ref_x`=0 a left edge → `ref_x` stays 0. `hit`=1 with a right edge → no change.
- `shape`=1 (w=4), `ref_x`=560 → right edge gives 560 (560+100 > 640); at `ref_x`=540 → 560.
- `stop` raised before a tick → `ref_y` frozen, LOCK 2 cycles, `change_shape` pulse, `ref_x`=280, `ref_y`=0.
- `stop`=1 during SPAWN and the following cycle → `game_over`=1 and sticky; buttons have no effect; `reset` clears it.
- `btn_drop` held → `ref_y` +20 every clock. `reset` asserted mid-fall → next cycle `ref_x`=280, `ref_y`=0, `game_over`=0.
